// File: rtl/usb_slave_regs_p.sv
// USB endpoint slave register block: AHB-side register file plus a byte
// sequencer that moves 1/2/4-byte DATA accesses through the endpoint buffer.
module usb_slave_regs_p #(
    parameter int unsigned BUF_DEPTH = 64,
    parameter int unsigned OCC_W     = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             req,
    input  logic             hwrite_reg,
    input  logic [1:0]       hsize,
    input  logic [2:0]       val_loc,
    input  logic [31:0]      hwdata,
    input  logic [2:0]       rx_packet,
    input  logic             rx_data_ready,
    input  logic             rx_transfer_active,
    input  logic             rx_error,
    input  logic             tx_transfer_active,
    input  logic             tx_error,
    input  logic [OCC_W-1:0] buffer_occupancy,
    input  logic [7:0]       rx_data,
    output logic [31:0]      hrdata,
    output logic             rd_valid,
    output logic             hold,
    output logic             get_rx_data,
    output logic             store_tx_data,
    output logic [7:0]       tx_data,
    output logic [1:0]       tx_packet,
    output logic             clear,
    output logic             d_mode,
    output logic             err_irq
);

    localparam logic [2:0] LocData   = 3'd0;
    localparam logic [2:0] LocStatus = 3'd1;
    localparam logic [2:0] LocError  = 3'd2;
    localparam logic [2:0] LocBufOcc = 3'd3;
    localparam logic [2:0] LocTxCtrl = 3'd4;
    localparam logic [2:0] LocFlush  = 3'd5;

    typedef enum logic [1:0] {StIdle, StMove, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;
    logic        dir_wr_q, dir_wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] hrdata_q, hrdata_d;
    logic        rd_valid_q, rd_valid_d;
    logic [3:0]  pkt_q, pkt_d;
    logic        err_rx_q, err_rx_d;
    logic        err_tx_q, err_tx_d;
    logic [7:0]  tx_ctrl_q, tx_ctrl_d;
    logic        tx_act_q;
    logic        flush_q, flush_d;

    logic [31:0] occ_32;
    logic        occ_nz, full, accept, acc_wr, can_move;
    logic [31:0] status_w, rd_mux;
    logic [7:0]  tx_byte;

    assign occ_32   = 32'(buffer_occupancy);
    assign occ_nz   = |buffer_occupancy;
    assign full     = occ_32 >= BUF_DEPTH;
    assign accept   = req && (state_q == StIdle);
    assign acc_wr   = accept && hwrite_reg;
    assign can_move = (state_q == StMove) && (dir_wr_q ? !full : occ_nz);

    // pkt_q is one-hot {nak, ack, out, in}
    assign status_w = {16'b0, 6'b0, (state_q != StIdle), full, 1'b0, tx_transfer_active,
                       rx_transfer_active, pkt_q, occ_nz};

    // Register read mux for non-DATA locations
    always_comb begin
        rd_mux = 32'h0;
        unique case (val_loc)
            LocStatus: rd_mux = status_w;
            LocError:  rd_mux = {23'b0, err_tx_q, 7'b0, err_rx_q};
            LocBufOcc: rd_mux = occ_32;
            LocTxCtrl: rd_mux = {24'b0, tx_ctrl_q};
            LocFlush:  rd_mux = {31'b0, flush_q};
            default:   rd_mux = 32'h0;
        endcase
    end

    // Select the latched write byte for the current byte index
    always_comb begin
        tx_byte = wdata_q[7:0];
        unique case (cnt_q)
            2'd0: tx_byte = wdata_q[7:0];
            2'd1: tx_byte = wdata_q[15:8];
            2'd2: tx_byte = wdata_q[23:16];
            2'd3: tx_byte = wdata_q[31:24];
        endcase
    end

    // Byte sequencer next state and read-data capture
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        dir_wr_d   = dir_wr_q;
        wdata_d    = wdata_q;
        hrdata_d   = hrdata_q;
        rd_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (val_loc == LocData) begin
                        state_d  = StMove;
                        cnt_d    = 2'd0;
                        dir_wr_d = hwrite_reg;
                        wdata_d  = hwdata;
                        hrdata_d = 32'h0; // unused upper lanes read 0
                        unique case (hsize)
                            2'd0:    last_d = 2'd0;
                            2'd1:    last_d = 2'd1;
                            default: last_d = 2'd3;
                        endcase
                    end else if (!hwrite_reg) begin
                        hrdata_d   = rd_mux;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            StMove: begin
                if (can_move) begin
                    if (!dir_wr_q) begin
                        unique case (cnt_q)
                            2'd0: hrdata_d[7:0]   = rx_data;
                            2'd1: hrdata_d[15:8]  = rx_data;
                            2'd2: hrdata_d[23:16] = rx_data;
                            2'd3: hrdata_d[31:24] = rx_data;
                        endcase
                    end
                    if (cnt_q == last_q) begin
                        state_d    = StDone;
                        rd_valid_d = !dir_wr_q;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Status, error, TX control and flush register next state
    always_comb begin
        pkt_d = pkt_q;
        if (rx_data_ready && (rx_packet != 3'd0)) begin
            unique case (rx_packet)
                3'd1:    pkt_d = 4'b0001;
                3'd2:    pkt_d = 4'b0010;
                3'd3:    pkt_d = 4'b0100;
                3'd4:    pkt_d = 4'b1000;
                default: pkt_d = 4'b0000;
            endcase
        end
        // A new error event wins over a same-cycle clear
        err_rx_d = rx_error | (err_rx_q & ~(acc_wr && (val_loc == LocError) && hwdata[0]));
        err_tx_d = tx_error | (err_tx_q & ~(acc_wr && (val_loc == LocError) && hwdata[8]));
        tx_ctrl_d = tx_ctrl_q;
        if (acc_wr && (val_loc == LocTxCtrl)) begin
            tx_ctrl_d = hwdata[7:0];
        end else if (tx_act_q && !tx_transfer_active) begin
            tx_ctrl_d = 8'h00;
        end
        flush_d = acc_wr && (val_loc == LocFlush) && hwdata[0];
    end

    // State registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            cnt_q      <= 2'd0;
            last_q     <= 2'd0;
            dir_wr_q   <= 1'b0;
            wdata_q    <= 32'h0;
            hrdata_q   <= 32'h0;
            rd_valid_q <= 1'b0;
            pkt_q      <= 4'h0;
            err_rx_q   <= 1'b0;
            err_tx_q   <= 1'b0;
            tx_ctrl_q  <= 8'h00;
            tx_act_q   <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            dir_wr_q   <= dir_wr_d;
            wdata_q    <= wdata_d;
            hrdata_q   <= hrdata_d;
            rd_valid_q <= rd_valid_d;
            pkt_q      <= pkt_d;
            err_rx_q   <= err_rx_d;
            err_tx_q   <= err_tx_d;
            tx_ctrl_q  <= tx_ctrl_d;
            tx_act_q   <= tx_transfer_active;
            flush_q    <= flush_d;
        end
    end

    assign hrdata        = hrdata_q;
    assign rd_valid      = rd_valid_q;
    assign hold          = (state_q == StMove);
    assign get_rx_data   = can_move && !dir_wr_q;
    assign store_tx_data = can_move && dir_wr_q;
    assign tx_data       = store_tx_data ? tx_byte : 8'h00;
    assign tx_packet     = tx_ctrl_q[1:0];
    assign clear         = flush_q;
    assign d_mode        = tx_transfer_active;
    assign err_irq       = err_rx_q | err_tx_q;

endmodule

// File: tb/tb_usb_slave_regs_p.sv
// Randomized bench for usb_slave_regs_p against a transaction-level model,
// plus directed scenarios with literal expectations.
module tb_usb_slave_regs_p;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned OW    = 7;

    logic          clk, n_rst, req, hwrite_reg;
    logic [1:0]    hsize;
    logic [2:0]    val_loc, rx_packet;
    logic [31:0]   hwdata;
    logic          rx_data_ready, rx_transfer_active, rx_error, tx_transfer_active, tx_error;
    logic [OW-1:0] buffer_occupancy;
    logic [7:0]    rx_data;
    logic [31:0]   hrdata;
    logic          rd_valid, hold, get_rx_data, store_tx_data, clear, d_mode, err_irq;
    logic [7:0]    tx_data;
    logic [1:0]    tx_packet;

    usb_slave_regs_p #(.BUF_DEPTH(DEPTH), .OCC_W(OW)) dut (
        .clk(clk), .n_rst(n_rst), .req(req), .hwrite_reg(hwrite_reg), .hsize(hsize),
        .val_loc(val_loc), .hwdata(hwdata), .rx_packet(rx_packet),
        .rx_data_ready(rx_data_ready), .rx_transfer_active(rx_transfer_active),
        .rx_error(rx_error), .tx_transfer_active(tx_transfer_active), .tx_error(tx_error),
        .buffer_occupancy(buffer_occupancy), .rx_data(rx_data), .hrdata(hrdata),
        .rd_valid(rd_valid), .hold(hold), .get_rx_data(get_rx_data),
        .store_tx_data(store_tx_data), .tx_data(tx_data), .tx_packet(tx_packet),
        .clear(clear), .d_mode(d_mode), .err_irq(err_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: one outstanding DATA transaction described by byte counts
    bit          m_busy, m_tail, m_write, m_rdv;
    int          m_total, m_done, m_pkt;
    logic [31:0] m_wdata, m_rword, m_hr;
    bit          m_err0, m_err8, m_txprev, m_flush;
    logic [7:0]  m_txctrl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_tail = 0; m_write = 0; m_rdv = 0; m_total = 0; m_done = 0; m_pkt = 0;
        m_wdata = 0; m_rword = 0; m_hr = 0; m_err0 = 0; m_err8 = 0; m_txprev = 0;
        m_flush = 0; m_txctrl = 0;
    endtask

    // Compare DUT outputs with the model, then advance the model one clock
    task automatic model_step();
        int          occ;
        bit          e_get, e_store, accept, wr;
        bit          rdv_n;
        logic [31:0] e_tx, status, rv;
        occ = int'(buffer_occupancy);
        if (!n_rst) begin
            model_reset();
            chk("rst_hold", hold, 0);
            chk("rst_rd_valid", rd_valid, 0);
            chk("rst_get", get_rx_data, 0);
            chk("rst_store", store_tx_data, 0);
            chk("rst_tx_data", tx_data, 0);
            chk("rst_tx_packet", tx_packet, 0);
            chk("rst_clear", clear, 0);
            chk("rst_err_irq", err_irq, 0);
            chk("rst_hrdata", hrdata, 0);
            return;
        end
        e_get   = m_busy && !m_write && occ != 0;
        e_store = m_busy && m_write && occ < DEPTH;
        e_tx    = e_store ? ((m_wdata >> (8 * m_done)) & 32'hff) : 32'h0;
        chk("hold", hold, 32'(m_busy));
        chk("get_rx_data", get_rx_data, 32'(e_get));
        chk("store_tx_data", store_tx_data, 32'(e_store));
        chk("tx_data", tx_data, e_tx);
        chk("rd_valid", rd_valid, 32'(m_rdv));
        if (m_rdv) chk("hrdata", hrdata, m_hr);
        chk("tx_packet", tx_packet, 32'(m_txctrl[1:0]));
        chk("clear", clear, 32'(m_flush));
        chk("d_mode", d_mode, 32'(tx_transfer_active));
        chk("err_irq", err_irq, 32'(m_err0 || m_err8));

        status = 0;
        status[0] = occ != 0;
        if (m_pkt >= 1 && m_pkt <= 4) status[m_pkt] = 1'b1;
        status[5] = rx_transfer_active;
        status[6] = tx_transfer_active;
        status[8] = occ >= DEPTH;
        status[9] = m_busy || m_tail;
        case (val_loc)
            3'd1:    rv = status;
            3'd2:    rv = (32'(m_err8) << 8) | 32'(m_err0);
            3'd3:    rv = 32'(occ);
            3'd4:    rv = 32'(m_txctrl);
            3'd5:    rv = 32'(m_flush);
            default: rv = 0;
        endcase

        accept = req && !m_busy && !m_tail;
        wr     = accept && hwrite_reg;
        rdv_n  = 0;
        if (m_tail) begin
            m_tail = 0;
        end else if (m_busy && (e_get || e_store)) begin
            if (e_get) m_rword = m_rword | (32'(rx_data) << (8 * m_done));
            m_done++;
            if (m_done == m_total) begin
                m_busy = 0;
                m_tail = 1;
                if (!m_write) begin
                    rdv_n = 1;
                    m_hr  = m_rword;
                end
            end
        end
        if (accept) begin
            if (val_loc == 3'd0) begin
                m_busy  = 1;
                m_total = (hsize == 2'd0) ? 1 : (hsize == 2'd1) ? 2 : 4;
                m_done  = 0;
                m_rword = 0;
                m_write = hwrite_reg;
                m_wdata = hwdata;
            end else if (!hwrite_reg) begin
                rdv_n = 1;
                m_hr  = rv;
            end
        end
        m_err0 = rx_error || (m_err0 && !(wr && val_loc == 3'd2 && hwdata[0]));
        m_err8 = tx_error || (m_err8 && !(wr && val_loc == 3'd2 && hwdata[8]));
        if (rx_data_ready && rx_packet != 3'd0) m_pkt = int'(rx_packet);
        if (wr && val_loc == 3'd4) m_txctrl = hwdata[7:0];
        else if (m_txprev && !tx_transfer_active) m_txctrl = 8'h00;
        m_txprev = tx_transfer_active;
        m_flush  = wr && val_loc == 3'd5 && hwdata[0];
        m_rdv    = rdv_n;
    endtask

    task automatic sample();
        @(negedge clk);
        model_step();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        req = 0; rx_error = 0; tx_error = 0; rx_data_ready = 0;
    endtask

    task automatic cyc();
        sample();
        adv();
    endtask

    task automatic access(input bit wr, input logic [2:0] loc, input logic [1:0] sz,
                          input logic [31:0] d);
        req = 1; hwrite_reg = wr; val_loc = loc; hsize = sz; hwdata = d;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        model_reset();
        n_rst = 0; req = 0; hwrite_reg = 0; hsize = 0; val_loc = 0; hwdata = 0;
        rx_packet = 0; rx_data_ready = 0; rx_transfer_active = 0; rx_error = 0;
        tx_transfer_active = 0; tx_error = 0; buffer_occupancy = 0; rx_data = 0;
        repeat (2) cyc();
        sample();
        chk("lit_rst_hold", hold, 0);
        chk("lit_rst_hrdata", hrdata, 0);
        adv();
        n_rst = 1;
        cyc();

        // 4-byte read
        buffer_occupancy = 10;
        access(0, 3'd0, 2'd2, 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'((i + 1) * 17);
            sample();
            chk("lit_r4_get", get_rx_data, 1);
            chk("lit_r4_hold", hold, 1);
            adv();
        end
        rx_data = 0;
        sample();
        chk("lit_r4_rd_valid", rd_valid, 1);
        chk("lit_r4_hrdata", hrdata, 32'h44332211);
        chk("lit_r4_hold_done", hold, 0);
        adv();
        cyc();

        // 2-byte write stalled by a full buffer
        buffer_occupancy = 7'(DEPTH);
        access(1, 3'd0, 2'd1, 32'hAABBCCDD);
        cyc();
        repeat (3) begin
            sample();
            chk("lit_w2_stall_store", store_tx_data, 0);
            chk("lit_w2_stall_hold", hold, 1);
            adv();
        end
        buffer_occupancy = 63;
        sample();
        chk("lit_w2_store0", store_tx_data, 1);
        chk("lit_w2_byte0", tx_data, 32'hDD);
        adv();
        sample();
        chk("lit_w2_byte1", tx_data, 32'hCC);
        adv();
        sample();
        chk("lit_w2_done_hold", hold, 0);
        chk("lit_w2_no_rdv", rd_valid, 0);
        adv();
        cyc();

        // Error set/clear priority
        rx_error = 1;
        cyc();
        sample();
        chk("lit_err_irq_set", err_irq, 1);
        adv();
        access(1, 3'd2, 2'd2, 32'h1);
        rx_error = 1;
        cyc();
        access(0, 3'd2, 2'd2, 0);
        cyc();
        sample();
        chk("lit_err_kept", hrdata, 32'h1);
        adv();
        access(1, 3'd2, 2'd2, 32'h1);
        cyc();
        sample();
        chk("lit_err_irq_clr", err_irq, 0);
        adv();
        access(0, 3'd2, 2'd2, 0);
        cyc();
        sample();
        chk("lit_err_cleared", hrdata, 0);
        adv();

        // Flush pulse
        access(1, 3'd5, 2'd2, 32'h1);
        cyc();
        sample();
        chk("lit_flush_pulse", clear, 1);
        adv();
        sample();
        chk("lit_flush_end", clear, 0);
        adv();
        access(0, 3'd5, 2'd2, 0);
        cyc();
        sample();
        chk("lit_flush_rdv", rd_valid, 1);
        chk("lit_flush_read", hrdata, 0);
        adv();

        // TX control cleared on falling tx_transfer_active
        access(1, 3'd4, 2'd2, 32'h2);
        cyc();
        tx_transfer_active = 1;
        repeat (2) begin
            sample();
            chk("lit_txpkt_held", tx_packet, 2);
            adv();
        end
        tx_transfer_active = 0;
        sample();
        chk("lit_txpkt_fall", tx_packet, 2);
        adv();
        sample();
        chk("lit_txpkt_clr", tx_packet, 0);
        adv();

        // Reset in the middle of a read
        buffer_occupancy = 10;
        access(0, 3'd0, 2'd2, 0);
        cyc();
        rx_data = 8'h11;
        cyc();
        rx_data = 8'h22;
        cyc();
        n_rst = 0;
        sample();
        chk("lit_abort_hold", hold, 0);
        chk("lit_abort_get", get_rx_data, 0);
        chk("lit_abort_rdv", rd_valid, 0);
        adv();
        n_rst = 1;
        cyc();
        cyc();
        access(0, 3'd0, 2'd0, 0);
        cyc();
        rx_data = 8'h5A;
        sample();
        chk("lit_r1_get", get_rx_data, 1);
        adv();
        rx_data = 0;
        sample();
        chk("lit_r1_rdv", rd_valid, 1);
        chk("lit_r1_hrdata", hrdata, 32'h5A);
        adv();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            n_rst         = ($urandom_range(0, 299) != 0);
            req           = ($urandom_range(0, 2) == 0);
            hwrite_reg    = 1'($urandom_range(0, 1));
            hsize         = 2'($urandom_range(0, 3));
            val_loc       = 3'($urandom_range(0, 7));
            hwdata        = $urandom;
            rx_packet     = 3'($urandom_range(0, 4));
            rx_data_ready = ($urandom_range(0, 3) == 0);
            rx_transfer_active = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) tx_transfer_active = ~tx_transfer_active;
            rx_error      = ($urandom_range(0, 15) == 0);
            tx_error      = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 7))
                0:       buffer_occupancy = 0;
                1:       buffer_occupancy = 63;
                2:       buffer_occupancy = 64;
                default: buffer_occupancy = 7'($urandom_range(0, 70));
            endcase
            rx_data = 8'($urandom_range(0, 255));
            cyc();
        end
        n_rst = 1;
        req = 0;
        repeat (6) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
